// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V style control FSM: sequences fetch/decode/execute/memory/writeback,
// stretches memory states by MEM_WAIT cycles and counts retired instructions.
module multicycle_control_unit #(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned EN_JAL   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             IorD,
    output logic             Branch,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       AluOp,
    output logic             pc_en,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JAL      = 4'd10,
        ST_TRAP     = 4'd11
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       i_or_d;
        logic       branch;
        logic       illegal;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    state_e           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic             opc_b5_q, opc_b5_d;
    logic [CNT_W-1:0] retired_q;
    ctrl_t            ctrl_q;
    logic             retire_c;

    // Moore output decode; 'last' marks the final cycle of a memory wait.
    function automatic ctrl_t decode_ctrl(input state_e s, input logic last);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.ir_write  = last;
                c.pc_write  = last;
            end
            ST_DECODE: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b10;
            end
            ST_MEMADR, ST_EXEC_I: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
            end
            ST_MEMREAD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_MEMWRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            ST_EXEC_R: begin
                c.alu_src_a = 2'b01;
                c.alu_op    = 2'b10;
            end
            ST_ALUWB: c.reg_write = 1'b1;
            ST_BRANCH: begin
                c.alu_src_a = 2'b01;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
            end
            ST_JAL: begin
                c.reg_write = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b10;
            end
            ST_TRAP: c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    // Next-state and wait-counter logic; the counter reloads on every state change.
    always_comb begin
        state_d  = state_q;
        wait_d   = WAIT_INIT;
        opc_b5_d = opc_b5_q;
        case (state_q)
            ST_FETCH: begin
                if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
                else                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                opc_b5_d = opcode[5];
                case (opcode)
                    7'b0000011, 7'b0100011: state_d = ST_MEMADR;
                    7'b0110011:             state_d = ST_EXEC_R;
                    7'b0010011:             state_d = ST_EXEC_I;
                    7'b1100011:             state_d = ST_BRANCH;
                    7'b1101111:             state_d = (EN_JAL != 0) ? ST_JAL : ST_TRAP;
                    default:                state_d = ST_TRAP;
                endcase
            end
            ST_MEMADR: state_d = opc_b5_q ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD: begin
                if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
                else                state_d = ST_MEMWB;
            end
            ST_MEMWRITE: begin
                if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
                else                state_d = ST_FETCH;
            end
            ST_EXEC_R, ST_EXEC_I: state_d = ST_ALUWB;
            default:              state_d = ST_FETCH;
        endcase
    end

    assign retire_c = (state_q == ST_MEMWB) || (state_q == ST_ALUWB) ||
                      (state_q == ST_BRANCH) || (state_q == ST_JAL) ||
                      ((state_q == ST_MEMWRITE) && (wait_q == 4'd0));

    // Control word is registered from the next state so it lines up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            wait_q    <= WAIT_INIT;
            opc_b5_q  <= 1'b0;
            retired_q <= '0;
            ctrl_q    <= decode_ctrl(ST_FETCH, WAIT_INIT == 4'd0);
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            opc_b5_q <= opc_b5_d;
            ctrl_q   <= decode_ctrl(state_d, wait_d == 4'd0);
            if (retire_c) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Write enables are suppressed for as long as reset is held.
    assign PCWrite  = ctrl_q.pc_write  & ~reset;
    assign IRWrite  = ctrl_q.ir_write  & ~reset;
    assign MemWrite = ctrl_q.mem_write & ~reset;
    assign RegWrite = ctrl_q.reg_write & ~reset;
    assign illegal  = ctrl_q.illegal   & ~reset;
    assign pc_en    = (ctrl_q.pc_write | (ctrl_q.branch & zero)) & ~reset;
    assign MemRead  = ctrl_q.mem_read;
    assign MemtoReg = ctrl_q.mem_to_reg;
    assign IorD     = ctrl_q.i_or_d;
    assign Branch   = ctrl_q.branch;
    assign ALUSrcA  = ctrl_q.alu_src_a;
    assign ALUSrcB  = ctrl_q.alu_src_b;
    assign AluOp    = ctrl_q.alu_op;
    assign state    = 4'(state_q);
    assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: two instances (no-wait/4-bit counter/JAL on,
// 2-wait/32-bit counter/JAL off) driven with directed instruction sequences.
module tb_multicycle_control_unit;

    typedef struct {
        bit          dsel;
        logic [3:0]  st;
        bit          fin;
        bit          rst;
        bit          z;
        logic [31:0] ret;
        int          idx;
    } exp_t;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic       clk;
    logic       rst0, rst1;
    logic [6:0] op;
    logic       zr;

    logic       pcw0, irw0, mrd0, mwr0, rgw0, m2r0, iod0, br0, pce0, ill0;
    logic [1:0] sa0, sb0, ao0;
    logic [3:0] st0;
    logic [3:0] ret0;
    logic       pcw1, irw1, mrd1, mwr1, rgw1, m2r1, iod1, br1, pce1, ill1;
    logic [1:0] sa1, sb1, ao1;
    logic [3:0] st1;
    logic [31:0] ret1;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_push = 0;

    multicycle_control_unit #(.MEM_WAIT(0), .CNT_W(4), .EN_JAL(1)) dut0 (
        .clk(clk), .reset(rst0), .opcode(op), .zero(zr),
        .PCWrite(pcw0), .IRWrite(irw0), .MemRead(mrd0), .MemWrite(mwr0),
        .RegWrite(rgw0), .MemtoReg(m2r0), .IorD(iod0), .Branch(br0),
        .ALUSrcA(sa0), .ALUSrcB(sb0), .AluOp(ao0), .pc_en(pce0),
        .state(st0), .illegal(ill0), .retired(ret0)
    );

    multicycle_control_unit #(.MEM_WAIT(2), .CNT_W(32), .EN_JAL(0)) dut1 (
        .clk(clk), .reset(rst1), .opcode(op), .zero(zr),
        .PCWrite(pcw1), .IRWrite(irw1), .MemRead(mrd1), .MemWrite(mwr1),
        .RegWrite(rgw1), .MemtoReg(m2r1), .IorD(iod1), .Branch(br1),
        .ALUSrcA(sa1), .ALUSrcB(sb1), .AluOp(ao1), .pc_en(pce1),
        .state(st1), .illegal(ill1), .retired(ret1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference control word per state, taken from the state/output table.
    function automatic logic [15:0] spec_ctrl(input logic [3:0] st, input bit fin,
                                              input bit rst, input bit z);
        logic pcw, irw, mrd, mwr, rgw, m2r, iod, br, pce, ill;
        logic [1:0] sa, sb, ao;
        {pcw, irw, mrd, mwr, rgw, m2r, iod, br, ill} = '0;
        sa = 2'b00; sb = 2'b00; ao = 2'b00;
        case (st)
            4'd0:  begin mrd = 1'b1; sb = 2'b01; pcw = fin; irw = fin; end
            4'd1:  begin sa = 2'b10; sb = 2'b10; end
            4'd2:  begin sa = 2'b01; sb = 2'b10; end
            4'd3:  begin mrd = 1'b1; iod = 1'b1; end
            4'd4:  begin rgw = 1'b1; m2r = 1'b1; end
            4'd5:  begin mwr = 1'b1; iod = 1'b1; end
            4'd6:  begin sa = 2'b01; ao = 2'b10; end
            4'd7:  rgw = 1'b1;
            4'd8:  begin sa = 2'b01; sb = 2'b10; end
            4'd9:  begin sa = 2'b01; ao = 2'b01; br = 1'b1; end
            4'd10: begin rgw = 1'b1; pcw = 1'b1; sa = 2'b10; sb = 2'b10; end
            4'd11: ill = 1'b1;
            default: ;
        endcase
        pce = pcw | (br & z);
        if (rst) {pcw, irw, mwr, rgw, pce, ill} = '0;
        return {pcw, irw, mrd, mwr, rgw, m2r, iod, br, sa, sb, ao, pce, ill};
    endfunction

    // Monitor: every cycle with a queued expectation is compared at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [15:0] act_c, exp_c;
            logic [3:0]  act_s;
            logic [31:0] act_r;
            e = exp_q.pop_front();
            if (e.dsel == 1'b0) begin
                act_c = {pcw0, irw0, mrd0, mwr0, rgw0, m2r0, iod0, br0, sa0, sb0, ao0, pce0, ill0};
                act_s = st0;
                act_r = {28'd0, ret0};
            end else begin
                act_c = {pcw1, irw1, mrd1, mwr1, rgw1, m2r1, iod1, br1, sa1, sb1, ao1, pce1, ill1};
                act_s = st1;
                act_r = ret1;
            end
            exp_c = spec_ctrl(e.st, e.fin, e.rst, e.z);
            n_vec++;
            if (act_s !== e.st || act_c !== exp_c || act_r !== e.ret) begin
                n_err++;
                $display("FAIL vec%0d dut%0d: got state=%0d ctrl=%h retired=%0d, required state=%0d ctrl=%h retired=%0d",
                         e.idx, e.dsel, act_s, act_c, act_r, e.st, exp_c, e.ret);
            end
        end
    end

    // Queue the expectation for the current cycle, then advance one clock.
    task automatic step(input bit d, input logic [3:0] st, input bit fin, input logic [31:0] ret);
        exp_t e;
        e.dsel = d; e.st = st; e.fin = fin; e.z = zr; e.ret = ret; e.idx = n_push;
        e.rst  = d ? rst1 : rst0;
        n_push++;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One instruction: nf FETCH cycles (write on the last), then nb body states.
    task automatic instr(input bit d, input logic [6:0] o, input bit z, input int nf,
                         input logic [3:0] body[8], input int nb, input logic [31:0] ret);
        op = o;
        zr = z;
        for (int k = 0; k < nf; k++) step(d, 4'd0, k == nf - 1, ret);
        for (int k = 0; k < nb; k++) step(d, body[k], 1'b0, ret);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; op = 7'd0; zr = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Instance 0: no memory waits, 4-bit counter, JAL enabled.
        step(1'b0, 4'd0, 1'b1, 0);
        rst0 = 1'b0;
        instr(1'b0, OP_R,   1'b0, 1, '{1, 6, 7, 0, 0, 0, 0, 0}, 3, 0);
        instr(1'b0, OP_LD,  1'b0, 1, '{1, 2, 3, 4, 0, 0, 0, 0}, 4, 1);
        instr(1'b0, OP_ST,  1'b0, 1, '{1, 2, 5, 0, 0, 0, 0, 0}, 3, 2);
        instr(1'b0, OP_I,   1'b0, 1, '{1, 8, 7, 0, 0, 0, 0, 0}, 3, 3);
        instr(1'b0, OP_BR,  1'b1, 1, '{1, 9, 0, 0, 0, 0, 0, 0}, 2, 4);
        instr(1'b0, OP_BR,  1'b0, 1, '{1, 9, 0, 0, 0, 0, 0, 0}, 2, 5);
        instr(1'b0, OP_JAL, 1'b0, 1, '{1, 10, 0, 0, 0, 0, 0, 0}, 2, 6);
        instr(1'b0, OP_BAD, 1'b0, 1, '{1, 11, 0, 0, 0, 0, 0, 0}, 2, 7);
        // Store aborted by reset while in MEMADR.
        instr(1'b0, OP_ST,  1'b0, 1, '{1, 0, 0, 0, 0, 0, 0, 0}, 1, 7);
        rst0 = 1'b1;
        step(1'b0, 4'd2, 1'b0, 7);
        step(1'b0, 4'd0, 1'b1, 0);
        rst0 = 1'b0;
        // Sixteen R-types wrap the 4-bit counter back to zero.
        for (int i = 0; i < 16; i++)
            instr(1'b0, OP_R, 1'b0, 1, '{1, 6, 7, 0, 0, 0, 0, 0}, 3, 32'(i));
        step(1'b0, 4'd0, 1'b1, 0);
        rst0 = 1'b1;

        // Instance 1: two wait cycles per memory state, JAL disabled.
        step(1'b1, 4'd0, 1'b0, 0);
        rst1 = 1'b0;
        instr(1'b1, OP_LD,  1'b0, 3, '{1, 2, 3, 3, 3, 4, 0, 0}, 6, 0);
        instr(1'b1, OP_ST,  1'b0, 3, '{1, 2, 5, 5, 5, 0, 0, 0}, 5, 1);
        instr(1'b1, OP_BAD, 1'b0, 3, '{1, 11, 0, 0, 0, 0, 0, 0}, 2, 2);
        instr(1'b1, OP_JAL, 1'b0, 3, '{1, 11, 0, 0, 0, 0, 0, 0}, 2, 2);
        // Load aborted by reset during the MEMREAD wait.
        instr(1'b1, OP_LD,  1'b0, 3, '{1, 2, 3, 0, 0, 0, 0, 0}, 2, 2);
        rst1 = 1'b1;
        step(1'b1, 4'd3, 1'b0, 2);
        step(1'b1, 4'd0, 1'b0, 0);
        rst1 = 1'b0;
        instr(1'b1, OP_R,   1'b0, 3, '{1, 6, 7, 0, 0, 0, 0, 0}, 3, 0);
        step(1'b1, 4'd0, 1'b0, 1);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
